// File: rtl/lcd_hex_display.sv
// Drives an HD44780 16x2 LCD in 8-bit write-only mode. It renders up to two
// latched DATA_W-bit values as uppercase hex, one value per line.
module lcd_hex_display #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 2,
    parameter int PREFIX      = 1,
    parameter int POWERUP_CYC = 1000000,
    parameter int EN_CYC      = 16,
    parameter int GAP_CYC     = 2000,
    parameter int CLEAR_CYC   = 80000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [7:0]        LCD_DATA,
    output logic              LCD_RW,
    output logic              LCD_EN,
    output logic              LCD_RS,
    output logic              LCD_ON,
    output logic              LCD_BLON
);

    localparam int NCHARS = DATA_W / 4 + 2 * PREFIX;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHARS} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

    state_t            state, nx_state;
    phase_t            phase;
    logic [31:0]       cnt;
    logic [31:0]       wait_len;
    logic [4:0]        idx, nx_idx;
    logic              line, nx_line;
    logic              start;
    logic              tx_done;
    logic [7:0]        nx_byte;
    logic [CH_W-1:0]   pick;
    logic [NUM_CH-1:0] dirty;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] render;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] tx_byte(input state_t st, input logic [4:0] i,
                                           input logic ln, input logic [DATA_W-1:0] val);
        logic [DATA_W-1:0] sh;
        int k;
        tx_byte = 8'h00;
        case (st)
            INIT: begin
                case (i)
                    5'd0:    tx_byte = 8'h38;
                    5'd1:    tx_byte = 8'h0C;
                    5'd2:    tx_byte = 8'h01;
                    default: tx_byte = 8'h06;
                endcase
            end
            ADDR: tx_byte = ln ? 8'hC0 : 8'h80;
            CHARS: begin
                if (PREFIX != 0 && i == 5'd0) begin
                    tx_byte = 8'h30;
                end else if (PREFIX != 0 && i == 5'd1) begin
                    tx_byte = 8'h78;
                end else begin
                    k  = int'(i) - 2 * PREFIX;
                    sh = val >> (DATA_W - 4 - 4 * k);
                    tx_byte = hex_char(sh[3:0]);
                end
            end
            default: tx_byte = 8'h00;
        endcase
    endfunction

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;
    assign busy     = (state != IDLE) || (|dirty);

    // Decide the next transaction; its byte is loaded when SETUP is entered.
    always_comb begin
        wait_len = (state == INIT && idx == 5'd2) ? 32'(CLEAR_CYC) : 32'(GAP_CYC);
        tx_done  = (phase == PH_WAIT) && (cnt == wait_len - 32'd1);
        pick     = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (dirty[c]) pick = CH_W'(c);
        end
        start    = 1'b0;
        nx_state = state;
        nx_idx   = idx;
        nx_line  = line;
        case (state)
            PWRUP: begin
                if (cnt == 32'(POWERUP_CYC - 1)) begin
                    start    = 1'b1;
                    nx_state = INIT;
                    nx_idx   = '0;
                end
            end
            IDLE: begin
                if (|dirty) begin
                    start    = 1'b1;
                    nx_state = ADDR;
                    nx_idx   = '0;
                    nx_line  = (NUM_CH > 1) && (pick == CH_W'(1));
                end
            end
            INIT: begin
                if (tx_done) begin
                    if (idx == 5'd3) begin
                        nx_state = IDLE;
                    end else begin
                        start  = 1'b1;
                        nx_idx = idx + 5'd1;
                    end
                end
            end
            ADDR: begin
                if (tx_done) begin
                    start    = 1'b1;
                    nx_state = CHARS;
                    nx_idx   = '0;
                end
            end
            CHARS: begin
                if (tx_done) begin
                    if (idx == 5'(NCHARS - 1)) begin
                        nx_state = IDLE;
                    end else begin
                        start  = 1'b1;
                        nx_idx = idx + 5'd1;
                    end
                end
            end
            default: nx_state = IDLE;
        endcase
        nx_byte = tx_byte(nx_state, nx_idx, nx_line, render);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= PWRUP;
            phase    <= PH_SETUP;
            cnt      <= '0;
            idx      <= '0;
            line     <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
            render   <= '0;
            dirty    <= '1;
            for (int c = 0; c < NUM_CH; c++) shadow[c] <= '0;
        end else begin
            state <= nx_state;
            idx   <= nx_idx;
            line  <= nx_line;
            if (start) begin
                phase    <= PH_SETUP;
                cnt      <= '0;
                LCD_DATA <= nx_byte;
                LCD_RS   <= (nx_state == CHARS);
            end else if (nx_state == IDLE) begin
                phase <= PH_SETUP;
                cnt   <= '0;
            end else begin
                case (phase)
                    PH_SETUP: begin
                        if (state == PWRUP) begin
                            cnt <= cnt + 32'd1;
                        end else begin
                            phase  <= PH_EN;
                            LCD_EN <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                    PH_EN: begin
                        if (cnt == 32'(EN_CYC - 1)) begin
                            LCD_EN <= 1'b0;
                            phase  <= PH_WAIT;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: cnt <= cnt + 32'd1;
                endcase
            end
            // Snapshot clear first so a same-cycle write re-marks the channel dirty.
            if (state == IDLE && (|dirty)) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (pick == CH_W'(c)) begin
                        render   <= shadow[c];
                        dirty[c] <= 1'b0;
                    end
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && (NUM_CH == 1 || wr_ch == CH_W'(c))) begin
                    shadow[c] <= wr_data;
                    dirty[c]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_hex_display.sv
// Bench for lcd_hex_display: two instances (two-line 32-bit and one-line
// 16-bit without prefix) with expected LCD bytes kept in scoreboard queues.
module tb_lcd_hex_display;

    localparam int PW = 20;
    localparam int EC = 4;
    localparam int GC = 8;
    localparam int CC = 40;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        wr_en, wr_ch, busy, lcd_rw, lcd_en, lcd_rs, lcd_on, lcd_blon;
    logic [31:0] wr_data;
    logic [7:0]  lcd_data;

    logic        wr_en2, wr_ch2, busy2, lcd_rw2, lcd_en2, lcd_rs2, lcd_on2, lcd_blon2;
    logic [15:0] wr_data2;
    logic [7:0]  lcd_data2;

    lcd_hex_display #(.POWERUP_CYC(PW), .EN_CYC(EC), .GAP_CYC(GC), .CLEAR_CYC(CC)) dut (
        .CLK(clk), .Reset(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .busy(busy), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
        .LCD_RS(lcd_rs), .LCD_ON(lcd_on), .LCD_BLON(lcd_blon)
    );

    lcd_hex_display #(.DATA_W(16), .NUM_CH(1), .PREFIX(0), .POWERUP_CYC(PW),
                      .EN_CYC(EC), .GAP_CYC(GC), .CLEAR_CYC(CC)) dut16 (
        .CLK(clk), .Reset(rst), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_data(wr_data2),
        .busy(busy2), .LCD_DATA(lcd_data2), .LCD_RW(lcd_rw2), .LCD_EN(lcd_en2),
        .LCD_RS(lcd_rs2), .LCD_ON(lcd_on2), .LCD_BLON(lcd_blon2)
    );

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp2[$];
    logic [7:0] hex_lut[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endfunction

    function automatic void push_line(input logic ch, input logic [31:0] v);
        exp_q.push_back({1'b0, ch ? 8'hC0 : 8'h80});
        exp_q.push_back({1'b1, 8'h30});
        exp_q.push_back({1'b1, 8'h78});
        for (int k = 7; k >= 0; k--) exp_q.push_back({1'b1, hex_lut[v[4*k +: 4]]});
    endfunction

    function automatic void push_init16();
        exp2.push_back({1'b0, 8'h38});
        exp2.push_back({1'b0, 8'h0C});
        exp2.push_back({1'b0, 8'h01});
        exp2.push_back({1'b0, 8'h06});
        exp2.push_back({1'b0, 8'h80});
        for (int k = 0; k < 4; k++) exp2.push_back({1'b1, 8'h30});
    endfunction

    // Monitor for the 32-bit instance: byte order, EN width, stability, busy.
    int   cyc = 0, pulses = 0, hi_len = 0, last_fall = 0;
    logic en_prev = 1'b0, busy_prev = 1'b1;
    logic [8:0] cur = '0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            en_prev   = 1'b0;
            hi_len    = 0;
            busy_prev = 1'b1;
        end else begin
            if (lcd_en && !en_prev) begin
                pulses++;
                hi_len = 1;
                cur = {lcd_rs, lcd_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got 0x%0h expected none", cur);
                end else begin
                    check("lcd_byte", cur, exp_q.pop_front());
                end
            end else if (lcd_en) begin
                hi_len++;
                check("stable_while_en", {lcd_rs, lcd_data}, cur);
            end else if (en_prev) begin
                check("en_width", hi_len, EC);
                last_fall = cyc;
            end
            if (exp_q.size() != 0) check("busy_while_pending", busy, 1);
            if (!busy && busy_prev) check("busy_fall_gap", cyc - last_fall, GC);
            en_prev   = lcd_en;
            busy_prev = busy;
        end
    end

    logic en2_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            en2_prev = 1'b0;
        end else begin
            if (lcd_en2 && !en2_prev) begin
                if (exp2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse16: got 0x%0h expected none", {lcd_rs2, lcd_data2});
                end else begin
                    check("lcd_byte16", {lcd_rs2, lcd_data2}, exp2.pop_front());
                end
            end
            en2_prev = lcd_en2;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = !busy && !busy2 && exp_q.size() == 0 && exp2.size() == 0;
        end
        check("idle_reached", done, 1'b1);
        check("lcd_static", {lcd_rw, lcd_on, lcd_blon}, 3'b011);
    endtask

    task automatic wr1(input logic ch, input logic [31:0] v);
        step();
        wr_en = 1'b1;
        wr_ch = ch;
        wr_data = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_pulses(input int target);
        int n;
        n = 0;
        while (pulses < target && n < 2000) begin
            step();
            n++;
        end
        check("pulse_wait", pulses >= target, 1'b1);
    endtask

    typedef struct {
        logic        ch;
        logic [31:0] val;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] db[11];

    initial begin
        int p0, n;
        tbl[0] = '{1'b0, 32'hFFFFFFFF};
        tbl[1] = '{1'b1, 32'h0123ABCD};
        tbl[2] = '{1'b0, 32'h9A5C3E7F};
        tbl[3] = '{1'b1, 32'h00000000};
        tbl[4] = '{1'b0, 32'h80000001};
        db = '{8'hC0, 8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};

        rst = 1'b1;
        wr_en = 1'b0; wr_ch = 1'b0; wr_data = '0;
        wr_en2 = 1'b0; wr_ch2 = 1'b0; wr_data2 = '0;
        repeat (3) step();
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_busy", busy, 1'b1);
        check("rst_busy16", busy2, 1'b1);

        // Power-up: init commands, then both zero lines.
        push_init();
        push_line(1'b0, 32'h0);
        push_line(1'b1, 32'h0);
        push_init16();
        rst = 1'b0;
        wait_idle(2000);

        // Channel 1 only, explicit expected bytes.
        wr1(1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 11; i++) exp_q.push_back({(i != 0), db[i]});
        wait_idle(1000);

        for (int i = 0; i < 5; i++) begin
            wr1(tbl[i].ch, tbl[i].val);
            push_line(tbl[i].ch, tbl[i].val);
            wait_idle(1000);
        end

        // Write during the 3rd character of a channel-0 refresh.
        wr1(1'b0, 32'h0);
        push_line(1'b0, 32'h0);
        p0 = pulses;
        wait_pulses(p0 + 4);
        wr1(1'b0, 32'h12345678);
        push_line(1'b0, 32'h12345678);
        wait_idle(1000);

        // Back-to-back writes to ch0 then ch1 while idle.
        step();
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 32'hCAFE0001;
        step();
        wr_ch = 1'b1; wr_data = 32'h0BADF00D;
        step();
        wr_en = 1'b0;
        push_line(1'b0, 32'hCAFE0001);
        push_line(1'b1, 32'h0BADF00D);
        wait_idle(1000);

        // Second write lands on the snapshot cycle: old value first, then new.
        step();
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 32'hAAAA5555;
        step();
        wr_data = 32'h5555AAAA;
        step();
        wr_en = 1'b0;
        push_line(1'b0, 32'hAAAA5555);
        push_line(1'b0, 32'h5555AAAA);
        wait_idle(1000);

        // 16-bit single-channel instance, wr_ch ignored.
        step();
        wr_en2 = 1'b1; wr_ch2 = 1'b1; wr_data2 = 16'hA0F3;
        step();
        wr_en2 = 1'b0;
        exp2.push_back({1'b0, 8'h80});
        exp2.push_back({1'b1, 8'h41});
        exp2.push_back({1'b1, 8'h30});
        exp2.push_back({1'b1, 8'h46});
        exp2.push_back({1'b1, 8'h33});
        wait_idle(1000);

        // Reset in the middle of an EN-high pulse.
        wr1(1'b1, 32'h55AA00FF);
        push_line(1'b1, 32'h55AA00FF);
        p0 = pulses;
        wait_pulses(p0 + 2);
        step();
        check("en_before_rst", lcd_en, 1'b1);
        rst = 1'b1;
        #1;
        check("en_drop_on_rst", lcd_en, 1'b0);
        check("data_on_rst", lcd_data, 8'h00);
        exp_q.delete();
        exp2.delete();
        step();
        step();
        push_init();
        push_line(1'b0, 32'h0);
        push_line(1'b1, 32'h0);
        push_init16();
        rst = 1'b0;
        n = 0;
        while (!lcd_en && n < 200) begin
            step();
            n++;
        end
        check("pwrup_len", n, PW + 1);
        check("restart_byte", lcd_data, 8'h38);
        wait_idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
